// File: rtl/encoder8_3_pkg.sv
// Shared types and helpers for the 8-to-3 request encoder and its 3-to-8 decoder partner.
package encoder8_3_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_t;

  // Same mapping as the decoder: bit i is set for code {A,B,C} == i.
  function automatic req_t onehot(input idx_t idx);
    req_t r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pri_sel8.sv
// Combinational 8-bit selector: highest set bit (fixed) or first set bit after ptr (round-robin).
module pri_sel8
  import encoder8_3_pkg::*;
(
  input  req_t vec,
  input  idx_t ptr,
  input  logic rr_mode,
  output idx_t idx,
  output logic any
);

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    idx = '0;
    any = |vec;
    if (!rr_mode) begin
      // Ascending scan, last hit wins: the highest set bit.
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) idx = idx_t'(i);
      end
    end else begin
      // Descending distance, last hit wins: the nearest set bit after ptr, ptr itself last.
      for (int k = N_REQ; k >= 1; k--) begin
        if (vec[ptr + idx_t'(k)]) idx = ptr + idx_t'(k);
      end
    end
  end

endmodule

// File: rtl/encoder8_3_queue.sv
// Sequential 8-to-3 request encoder: pending register, one grant per handshake on {A,B,C}.
module encoder8_3_queue
  import encoder8_3_pkg::*;
#(
  parameter bit RR = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] REQ,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       VALID,
  input  logic       READY,
  output logic [7:0] PEND
);

  req_t pend_q, pend_d;
  idx_t out_idx_q, out_idx_d;
  idx_t ptr_q, ptr_d;
  logic valid_q, valid_d;

  idx_t cand;
  logic any;
  logic acc;
  logic can_load;
  logic load;

  pri_sel8 u_sel (
    .vec     (pend_q),
    .ptr     (ptr_q),
    .rr_mode (RR),
    .idx     (cand),
    .any     (any)
  );

  always_comb begin
    acc       = valid_q & READY;
    can_load  = ~valid_q | acc;
    load      = can_load & any;
    out_idx_d = out_idx_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    // A request arriving for the index being granted re-pends it.
    pend_d    = (pend_q & ~(load ? onehot(cand) : '0)) | REQ;
    if (load) begin
      out_idx_d = cand;
      valid_d   = 1'b1;
      ptr_d     = cand;
    end else if (acc) begin
      valid_d   = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q    <= '0;
      out_idx_q <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= idx_t'(N_REQ - 1);
    end else begin
      pend_q    <= pend_d;
      out_idx_q <= out_idx_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign {A, B, C} = out_idx_q;
  assign VALID     = valid_q;
  assign PEND      = pend_q;

endmodule

// File: tb/tb_encoder8_3_queue.sv
// Scoreboard bench: fixed-priority and round-robin instances, directed vectors, in-order grant checking.
module tb_encoder8_3_queue;

  logic       CLK;
  logic       RST;
  logic [7:0] req0, req1;
  logic       ready0, ready1;
  logic       a0, b0, c0, a1, b1, c1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;

  logic [7:0] abc0, abc1, v0, v1;
  assign abc0 = {5'b0, a0, b0, c0};
  assign abc1 = {5'b0, a1, b1, c1};
  assign v0   = {7'b0, valid0};
  assign v1   = {7'b0, valid1};

  int errors = 0;
  int checks = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  encoder8_3_queue #(.RR(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .REQ(req0), .A(a0), .B(b0), .C(c0),
    .VALID(valid0), .READY(ready0), .PEND(pend0)
  );

  encoder8_3_queue #(.RR(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(req1), .A(a1), .B(b1), .C(c1),
    .VALID(valid1), .READY(ready1), .PEND(pend1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitors: an accepted grant is VALID && READY seen mid-cycle, before the accepting edge.
  always @(negedge CLK) begin
    if (valid0 && ready0) begin
      if (q0.size() == 0) begin
        errors++; checks++;
        $display("FAIL grant0_unexpected: got %0d expected none at %0t", abc0, $time);
      end else check("grant0", abc0, q0.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (valid1 && ready1) begin
      if (q1.size() == 0) begin
        errors++; checks++;
        $display("FAIL grant1_unexpected: got %0d expected none at %0t", abc1, $time);
      end else check("grant1", abc1, q1.pop_front());
    end
  end

  initial begin
    RST = 1'b1; req0 = '0; req1 = '0; ready0 = 1'b0; ready1 = 1'b0;
    step(2);
    RST = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid0", v0, 8'd0);
      check("idle_abc0", abc0, 8'd0);
      check("idle_pend0", pend0, 8'h00);
      check("idle_valid1", v1, 8'd0);
      check("idle_pend1", pend1, 8'h00);
    end

    // Fixed priority burst: 7, 5, 2
    q0.push_back(8'd7); q0.push_back(8'd5); q0.push_back(8'd2);
    req0 = 8'hA4; ready0 = 1'b1;
    step();
    req0 = 8'h00;
    check("burst_pend", pend0, 8'hA4);
    step();
    check("burst_valid", v0, 8'd1);
    check("burst_first", abc0, 8'd7);
    step(3);
    check("burst_idle_valid", v0, 8'd0);
    check("burst_idle_pend", pend0, 8'h00);

    // Stall: index 0 held while index 7 accumulates
    q0.push_back(8'd0); q0.push_back(8'd7);
    ready0 = 1'b0; req0 = 8'h01;
    step();
    req0 = 8'h00;
    step();
    check("stall_valid", v0, 8'd1);
    check("stall_abc", abc0, 8'd0);
    req0 = 8'h80;
    step();
    req0 = 8'h00;
    check("stall_hold_abc", abc0, 8'd0);
    check("stall_hold_valid", v0, 8'd1);
    check("stall_pend", pend0, 8'h80);
    ready0 = 1'b1;
    step();
    check("stall_next", abc0, 8'd7);
    step();
    check("stall_done_valid", v0, 8'd0);
    check("stall_done_pend", pend0, 8'h00);

    // Set wins over clear on the load cycle: index 3 granted twice
    q0.push_back(8'd3); q0.push_back(8'd3);
    req0 = 8'h08;
    step();
    check("setwin_pend_a", pend0, 8'h08);
    step();
    req0 = 8'h00;
    check("setwin_abc", abc0, 8'd3);
    check("setwin_pend_b", pend0, 8'h08);
    step();
    check("setwin_again", abc0, 8'd3);
    check("setwin_valid", v0, 8'd1);
    check("setwin_pend_c", pend0, 8'h00);
    step();
    check("setwin_idle", v0, 8'd0);

    // Round-robin sweep: 0..7, 0..7, 0 with no gaps
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 8; k++) q1.push_back(8'(k));
    q1.push_back(8'd0);
    ready1 = 1'b1; req1 = 8'hFF;
    step();
    for (int k = 0; k < 17; k++) begin
      step();
      check("rr_no_gap", v1, 8'd1);
      if (k == 8) req1 = 8'h00;
    end
    step();
    check("rr_idle_valid", v1, 8'd0);
    check("rr_idle_pend", pend1, 8'h00);

    // Reset mid-operation drops the presented index and pending bits
    ready1 = 1'b0; req1 = 8'h30;
    step(2);
    req1 = 8'h00;
    check("mid_valid", v1, 8'd1);
    check("mid_pend", pend1, 8'h30);
    check("mid_abc", abc1, 8'd4);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_valid", v1, 8'd0);
    check("rst_pend", pend1, 8'h00);
    check("rst_abc", abc1, 8'd0);

    // After reset the round-robin search restarts at index 0
    q1.push_back(8'd0); q1.push_back(8'd7);
    ready1 = 1'b1; req1 = 8'h81;
    step();
    req1 = 8'h00;
    step();
    check("rst_rr_first", abc1, 8'd0);
    step();
    check("rst_rr_second", abc1, 8'd7);
    step();
    check("rst_rr_idle", v1, 8'd0);

    step(2);
    check("sb0_drained", 8'(q0.size()), 8'd0);
    check("sb1_drained", 8'(q1.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
